// File: rtl/pid_seq_pkg.sv
// Shared definitions for the PI control sequencer and the datapath ALU it drives.
// Holds the state encoding and the ALU source-select codes.
package pid_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ERR   = 3'd1,
        INTG  = 3'd2,
        ICOMP = 3'd3,
        PCOMP = 3'd4,
        ACC1  = 3'd5,
        ACC2  = 3'd6
    } state_t;

    // ALU source-1 select codes
    localparam logic [2:0] S1_ACCUM    = 3'd0;
    localparam logic [2:0] S1_ITERM    = 3'd1;
    localparam logic [2:0] S1_ERR_SE   = 3'd2;
    localparam logic [2:0] S1_ERR_HALF = 3'd3;
    localparam logic [2:0] S1_FWD      = 3'd4;

    // ALU source-0 select codes
    localparam logic [2:0] S0_A2D    = 3'd0;
    localparam logic [2:0] S0_INTGRL = 3'd1;
    localparam logic [2:0] S0_ICOMP  = 3'd2;
    localparam logic [2:0] S0_PCOMP  = 3'd3;
    localparam logic [2:0] S0_PTERM  = 3'd4;

    function automatic logic is_mul_state(input state_t s);
        return (s == ICOMP) || (s == PCOMP);
    endfunction

endpackage

// File: rtl/pid_seq.sv
// PI-plus-feedforward sequencer: steps the combinational ALU through one drive
// computation per start pulse and owns every registered ALU operand.
module pid_seq
    import pid_seq_pkg::*;
#(
    parameter int MUL_CYCLES = 2,
    parameter int INT_DEC    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] a2d_res,
    input  logic [11:0] setpt,
    input  logic [15:0] dst,
    output logic [2:0]  src0sel,
    output logic [2:0]  src1sel,
    output logic        multiply,
    output logic        sub,
    output logic        mult2,
    output logic        mult4,
    output logic        saturate,
    output logic [11:0] a2d_q,
    output logic [11:0] error,
    output logic [11:0] intgrl,
    output logic [15:0] icomp,
    output logic [15:0] pcomp,
    output logic [15:0] accum,
    output logic        busy,
    output logic        done,
    output logic [11:0] drive,
    output state_t      dbg_state,
    output logic [7:0]  dbg_dec_cnt
);

    localparam logic [7:0] MUL_LAST = 8'(MUL_CYCLES - 1);
    localparam logic [7:0] DEC_LAST = 8'(INT_DEC - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_mul_cnt;
    logic [7:0]  r_dec_cnt;
    logic        r_intg_en;
    logic        r_done;
    logic [11:0] r_a2d_q;
    logic [11:0] r_error;
    logic [11:0] r_intgrl;
    logic [15:0] r_icomp;
    logic [15:0] r_pcomp;
    logic [15:0] r_accum;
    logic [11:0] r_drive;
    logic        w_mul_last;

    assign w_mul_last = (r_mul_cnt == MUL_LAST);

    // Moore decode: ALU controls depend on state only
    always_comb begin
        w_next   = r_state;
        src0sel  = S0_A2D;
        src1sel  = S1_ACCUM;
        multiply = 1'b0;
        sub      = 1'b0;
        saturate = 1'b0;
        case (r_state)
            IDLE: if (start) w_next = ERR;
            ERR: begin
                src1sel  = S1_ACCUM;
                src0sel  = S0_A2D;
                sub      = 1'b1;
                saturate = 1'b1;
                w_next   = r_intg_en ? INTG : ICOMP;
            end
            INTG: begin
                src1sel  = S1_ERR_SE;
                src0sel  = S0_INTGRL;
                saturate = 1'b1;
                w_next   = ICOMP;
            end
            ICOMP: begin
                multiply = 1'b1;
                src1sel  = S1_ITERM;
                src0sel  = S0_INTGRL;
                if (w_mul_last) w_next = PCOMP;
            end
            PCOMP: begin
                multiply = 1'b1;
                src1sel  = S1_ERR_SE;
                src0sel  = S0_PTERM;
                if (w_mul_last) w_next = ACC1;
            end
            ACC1: begin
                src1sel = S1_FWD;
                src0sel = S0_PCOMP;
                sub     = 1'b1;
                w_next  = ACC2;
            end
            ACC2: begin
                src1sel  = S1_ACCUM;
                src0sel  = S0_ICOMP;
                saturate = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_mul_cnt <= '0;
            r_dec_cnt <= '0;
            r_intg_en <= 1'b0;
            r_done    <= 1'b0;
            r_a2d_q   <= '0;
            r_error   <= '0;
            r_intgrl  <= '0;
            r_icomp   <= '0;
            r_pcomp   <= '0;
            r_accum   <= '0;
            r_drive   <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == ACC2);
            // Restart the hold counter whenever a state is (re)entered
            if (r_state != w_next)
                r_mul_cnt <= '0;
            else if (is_mul_state(r_state))
                r_mul_cnt <= r_mul_cnt + 8'd1;
            case (r_state)
                IDLE: if (start) begin
                    r_a2d_q   <= a2d_res;
                    r_accum   <= {{4{setpt[11]}}, setpt};
                    r_intg_en <= (r_dec_cnt == DEC_LAST);
                    r_dec_cnt <= (r_dec_cnt == DEC_LAST) ? 8'd0 : r_dec_cnt + 8'd1;
                end
                ERR:   r_error  <= dst[11:0];
                INTG:  r_intgrl <= dst[11:0];
                ICOMP: if (w_mul_last) r_icomp <= dst;
                PCOMP: if (w_mul_last) r_pcomp <= dst;
                ACC1:  r_accum  <= dst;
                ACC2: begin
                    r_accum <= dst;
                    r_drive <= dst[11:0];
                end
                default: ;
            endcase
        end
    end

    assign mult2       = 1'b0;
    assign mult4       = 1'b0;
    assign a2d_q       = r_a2d_q;
    assign error       = r_error;
    assign intgrl      = r_intgrl;
    assign icomp       = r_icomp;
    assign pcomp       = r_pcomp;
    assign accum       = r_accum;
    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign drive       = r_drive;
    assign dbg_state   = r_state;
    assign dbg_dec_cnt = r_dec_cnt;

endmodule

// File: tb/tb_pid_seq.sv
// Directed bench for pid_seq: instance A runs against a behavioural ALU,
// instance B (MUL_CYCLES=3, INT_DEC=1) sees dst driven directly by the bench.
module tb_pid_seq;
    import pid_seq_pkg::*;

    localparam int ITERM_C = 2;
    localparam int PTERM_C = 3;
    localparam int FWD_C   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic [11:0] a2d_res = '0, setpt = '0;
    logic [15:0] dst_a, dst_b = 16'h1234;

    logic [2:0] s0_a, s1_a, s0_b, s1_b;
    logic mul_a, sub_a, m2_a, m4_a, sat_a, busy_a, done_a;
    logic mul_b, sub_b, m2_b, m4_b, sat_b, busy_b, done_b;
    logic [11:0] aq_a, er_a, ig_a, drv_a, aq_b, er_b, ig_b, drv_b;
    logic [15:0] ic_a, pc_a, acc_a, ic_b, pc_b, acc_b;
    state_t st_a, st_b;
    logic [7:0] dec_a, dec_b;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    pid_seq #(.MUL_CYCLES(2), .INT_DEC(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .a2d_res(a2d_res), .setpt(setpt),
        .dst(dst_a), .src0sel(s0_a), .src1sel(s1_a), .multiply(mul_a), .sub(sub_a),
        .mult2(m2_a), .mult4(m4_a), .saturate(sat_a), .a2d_q(aq_a), .error(er_a),
        .intgrl(ig_a), .icomp(ic_a), .pcomp(pc_a), .accum(acc_a), .busy(busy_a),
        .done(done_a), .drive(drv_a), .dbg_state(st_a), .dbg_dec_cnt(dec_a)
    );

    pid_seq #(.MUL_CYCLES(3), .INT_DEC(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .a2d_res(a2d_res), .setpt(setpt),
        .dst(dst_b), .src0sel(s0_b), .src1sel(s1_b), .multiply(mul_b), .sub(sub_b),
        .mult2(m2_b), .mult4(m4_b), .saturate(sat_b), .a2d_q(aq_b), .error(er_b),
        .intgrl(ig_b), .icomp(ic_b), .pcomp(pc_b), .accum(acc_b), .busy(busy_b),
        .done(done_b), .drive(drv_b), .dbg_state(st_b), .dbg_dec_cnt(dec_b)
    );

    // Behavioural ALU: src1 op src0, optional clamp to 12-bit signed
    function automatic logic [15:0] alu_model(
        input logic [2:0] s1, input logic [2:0] s0,
        input logic mul, input logic sb, input logic sat,
        input logic [15:0] acc, input logic [15:0] ic, input logic [15:0] pc,
        input logic [11:0] er, input logic [11:0] ig, input logic [11:0] aq);
        int a, b, r;
        case (s1)
            3'd0:    a = $signed(acc);
            3'd1:    a = ITERM_C;
            3'd2:    a = $signed(er);
            3'd3:    a = $signed(er) >>> 1;
            default: a = FWD_C;
        endcase
        case (s0)
            3'd0:    b = {20'd0, aq};
            3'd1:    b = $signed(ig);
            3'd2:    b = $signed(ic);
            3'd3:    b = $signed(pc);
            default: b = PTERM_C;
        endcase
        r = mul ? a * b : (sb ? a - b : a + b);
        if (sat) begin
            if (r > 2047) r = 2047;
            if (r < -2048) r = -2048;
        end
        return r[15:0];
    endfunction

    always_comb dst_a = alu_model(s1_a, s0_a, mul_a, sub_a, sat_a,
                                  acc_a, ic_a, pc_a, er_a, ig_a, aq_a);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Raise start now, count edges until done is seen (budget 40)
    task automatic run_a(output int lat, output bit saw_intg);
        lat = 0;
        saw_intg = 1'b0;
        start_a = 1'b1;
        while (lat < 40) begin
            tick();
            start_a = 1'b0;
            lat++;
            if (st_a == INTG) saw_intg = 1'b1;
            if (done_a) break;
        end
    endtask

    task automatic test_reset();
        int lat;
        int n;
        bit si;
        do_reset();
        chk_cnt++;
        if ({busy_a, done_a, drv_a, acc_a, er_a, ig_a, ic_a, pc_a, aq_a} !== '0) begin
            $display("FAIL reset_regs: got busy=%b done=%b drive=%h accum=%h error=%h want all 0",
                     busy_a, done_a, drv_a, acc_a, er_a);
        end else pass_cnt++;
        chk_cnt++;
        if (st_a !== IDLE || dec_a !== 8'd0) begin
            $display("FAIL reset_state: got state=%0d dec=%0d want 0/0", st_a, dec_a);
        end else pass_cnt++;
        setpt = 12'h100;
        a2d_res = 12'h0C0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        while (st_a != PCOMP && n < 20) begin
            tick();
            n++;
        end
        rst = 1'b1;
        #1;
        chk_cnt++;
        if (st_a !== IDLE || busy_a !== 1'b0 || er_a !== 12'h0 || acc_a !== 16'h0 ||
            dec_a !== 8'd0 || {s0_a, s1_a, mul_a, sub_a, sat_a} !== '0) begin
            $display("FAIL reset_midrun: got state=%0d busy=%b error=%h accum=%h dec=%0d want IDLE/0",
                     st_a, busy_a, er_a, acc_a, dec_a);
        end else pass_cnt++;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done_a) n++;
            if (i == 1) rst = 1'b0;
        end
        chk_cnt++;
        if (n != 0) $display("FAIL reset_no_done: got %0d done pulses want 0", n);
        else pass_cnt++;
        run_a(lat, si);
        chk_cnt++;
        if (lat != 8 || drv_a !== 12'hF50) begin
            $display("FAIL reset_rerun: got lat=%0d drive=%h want 8/f50", lat, drv_a);
        end else pass_cnt++;
    endtask

    task automatic test_basic();
        int lat;
        bit si;
        do_reset();
        setpt = 12'h100;
        a2d_res = 12'h0C0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk_cnt++;
        if (st_a !== ERR || s1_a !== 3'd0 || s0_a !== 3'd0 || sub_a !== 1'b1 ||
            sat_a !== 1'b1 || mul_a !== 1'b0 || m2_a !== 1'b0 || m4_a !== 1'b0 || busy_a !== 1'b1) begin
            $display("FAIL err_ctrl: got st=%0d s1=%0d s0=%0d sub=%b sat=%b mul=%b want 1/0/0/1/1/0",
                     st_a, s1_a, s0_a, sub_a, sat_a, mul_a);
        end else pass_cnt++;
        lat = 1;
        si = 1'b0;
        while (lat < 40) begin
            tick();
            lat++;
            if (lat == 2) begin
                chk_cnt++;
                if (er_a !== 12'h040) $display("FAIL err_value: got %h want 040", er_a);
                else pass_cnt++;
            end
            if (st_a == INTG) si = 1'b1;
            if (done_a) break;
        end
        chk_cnt++;
        if (si) $display("FAIL intg_skip: got INTG visited want skipped");
        else pass_cnt++;
        chk_cnt++;
        if (lat != 8) $display("FAIL basic_latency: got %0d want 8", lat);
        else pass_cnt++;
        chk_cnt++;
        if (drv_a !== 12'hF50 || pc_a !== 16'h00C0 || ic_a !== 16'h0000) begin
            $display("FAIL basic_drive: got drive=%h pcomp=%h icomp=%h want f50/00c0/0000",
                     drv_a, pc_a, ic_a);
        end else pass_cnt++;
        tick();
        chk_cnt++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) $display("FAIL done_pulse: got done=%b busy=%b want 0/0", done_a, busy_a);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat;
        bit si;
        do_reset();
        setpt = 12'h100;
        a2d_res = 12'h0C0;
        for (int r = 1; r <= 4; r++) begin
            run_a(lat, si);
            chk_cnt++;
            if (r < 4) begin
                if (si || ig_a !== 12'h000 || lat != 8) begin
                    $display("FAIL b2b_run%0d: got intg=%b intgrl=%h lat=%0d want 0/000/8", r, si, ig_a, lat);
                end else pass_cnt++;
            end else begin
                if (!si || ig_a !== 12'h040 || lat != 9 || drv_a !== 12'hFD0) begin
                    $display("FAIL b2b_run4: got intg=%b intgrl=%h lat=%0d drive=%h want 1/040/9/fd0",
                             si, ig_a, lat, drv_a);
                end else pass_cnt++;
            end
        end
    endtask

    task automatic test_busy_start();
        int n;
        int dones;
        logic [7:0] dec_exp;
        dec_exp = (dec_a == 8'd3) ? 8'd0 : dec_a + 8'd1;
        tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        while (st_a != ICOMP && n < 20) begin
            tick();
            n++;
        end
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk_cnt++;
        if (busy_a !== 1'b1) $display("FAIL busy_hold: got busy=%b want 1", busy_a);
        else pass_cnt++;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done_a) dones++;
        end
        chk_cnt++;
        if (dones != 1 || busy_a !== 1'b0) $display("FAIL busy_ignore: got dones=%0d busy=%b want 1/0", dones, busy_a);
        else pass_cnt++;
        chk_cnt++;
        if (dec_a !== dec_exp) $display("FAIL busy_dec: got %0d want %0d", dec_a, dec_exp);
        else pass_cnt++;
    endtask

    task automatic test_mul3();
        int icnt;
        int n;
        dst_b = 16'h1234;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        icnt = 0;
        n = 0;
        while (!done_b && n < 40) begin
            if (st_b == ICOMP && mul_b) icnt++;
            dst_b = (st_b == ICOMP && icnt == 3) ? 16'h5678 : 16'h1234;
            tick();
            n++;
        end
        chk_cnt++;
        if (ic_b !== 16'h5678) $display("FAIL mul3_icomp: got %h want 5678", ic_b);
        else pass_cnt++;
        chk_cnt++;
        if (icnt != 3) $display("FAIL mul3_cycles: got %0d want 3", icnt);
        else pass_cnt++;
        chk_cnt++;
        if (pc_b !== 16'h1234 || ig_b !== 12'h234) $display("FAIL mul3_pcomp: got pcomp=%h intgrl=%h want 1234/234", pc_b, ig_b);
        else pass_cnt++;
    endtask

    task automatic test_drive_hold();
        int n;
        logic [11:0] drv_before;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 40) begin
            dst_b = (st_b == ACC2) ? 16'h07FF : 16'h1234;
            tick();
            n++;
        end
        chk_cnt++;
        if (drv_b !== 12'h7FF || acc_b !== 16'h07FF || done_b !== 1'b1) begin
            $display("FAIL acc2_drive: got drive=%h accum=%h done=%b want 7ff/07ff/1", drv_b, acc_b, done_b);
        end else pass_cnt++;
        dst_b = 16'h0ABC;
        for (int i = 0; i < 5; i++) tick();
        chk_cnt++;
        if (drv_b !== 12'h7FF) $display("FAIL drive_hold_idle: got %h want 7ff", drv_b);
        else pass_cnt++;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        drv_before = 12'h000;
        while (!done_b && n < 40) begin
            if (st_b == ACC2) drv_before = drv_b;
            dst_b = (st_b == ACC2) ? 16'h0123 : 16'h1234;
            tick();
            n++;
        end
        chk_cnt++;
        if (drv_before !== 12'h7FF || drv_b !== 12'h123) begin
            $display("FAIL drive_update: got before=%h after=%h want 7ff/123", drv_before, drv_b);
        end else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_busy_start();
        test_mul3();
        test_drive_hold();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pid_seq.md
Name: pid_seq

Overview:
- Control sequencer that sits on the other side of the datapath ALU.
- Drives `src0sel`, `src1sel`, `multiply`, `sub`, `mult2`, `mult4` and `saturate`, and captures `dst` back into the operand registers (`error`, `intgrl`, `icomp`, `pcomp`, `accum`) that feed the ALU.
- One run computes a PI-plus-feedforward drive value from one A2D current sample and a setpoint.
- It is the owner of the ALU's registered operands; the ALU stays purely combinational.

Parameters:
- MUL_CYCLES, 2: cycles each multiply step is held before `dst` is captured (≥1).
- INT_DEC, 4: integrator updated once per INT_DEC runs (≥1; 1 = every run).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse: `a2d_res` and `setpt` valid
- a2d_res  in  12  current feedback sample
- setpt  in  12  signed setpoint
- dst  in  16  ALU result
- src0sel  out  3  ALU source-0 select
- src1sel  out  3  ALU source-1 select
- multiply, sub, mult2, mult4, saturate  out  1 each  ALU op controls
- a2d_q  out  12  registered sample to ALU
- error  out  12  registered error
- intgrl  out  12  registered integrator
- icomp  out  16  registered I component
- pcomp  out  16  registered P component
- accum  out  16  registered accumulator
- busy  out  1  run in progress
- done  out  1  one-cycle pulse, `drive` updated
- drive  out  12  final saturated drive

Behaviour:
- Reset (async, immediate, also mid-run):
  - state = IDLE.
  - All operand registers, `drive`, the decimation counter and the multiply counter clear to 0.
  - `busy` = 0, `done` = 0.
- ALU control outputs are a Moore decode of state. In IDLE: all selects 0 and all op bits 0. `mult2` and `mult4` are 0 in every state.
- IDLE: `start` = 1 is accepted.
  - `a2d_q` ← `a2d_res`.
  - `accum` ← sign-extended `setpt`.
  - `intg_en` ← (`dec_cnt` == INT_DEC−1).
  - `dec_cnt` advances, wrapping at INT_DEC−1.
  - Next state is ERR.
- ERR (1 cycle):
  - src1 = ACCUM, src0 = A2D, sub = 1, saturate = 1.
  - `error` ← `dst[11:0]`.
  - Next state is INTG if `intg_en`, else ICOMP.
- INTG (1 cycle):
  - src1 = ERR_SE, src0 = INTGRL, sub = 0, saturate = 1.
  - `intgrl` ← `dst[11:0]`.
- ICOMP (MUL_CYCLES cycles):
  - multiply = 1, src1 = ITERM, src0 = INTGRL.
  - `icomp` ← `dst` on the last cycle only.
- PCOMP (MUL_CYCLES cycles):
  - multiply = 1, src1 = ERR_SE, src0 = PTERM.
  - `pcomp` ← `dst` on the last cycle.
- ACC1 (1 cycle):
  - src1 = FWD, src0 = PCOMP, sub = 1, saturate = 0.
  - `accum` ← `dst`.
- ACC2 (1 cycle):
  - src1 = ACCUM, src0 = ICOMP, sub = 0, saturate = 1.
  - `accum` ← `dst` and `drive` ← `dst[11:0]`.
  - Next state is IDLE, with `done` = 1 for that cycle.
- `busy` = 1 in ERR through ACC2.
- Latency: with MUL_CYCLES = 2, `done` rises 8 cycles after the `start` edge without INTG, and 9 cycles with INTG.
- `start` while `busy`: ignored. The run is not restarted and `dec_cnt` does not advance.
- `start` coincident with `done` (IDLE): accepted, back-to-back runs.
- Multiply counter: resets on entry to each multiply state, counts 0..MUL_CYCLES−1.
- `drive` holds its value between runs.
- `intgrl` persists across runs; it is cleared only by reset.

Decomposition:
- Shared package `pid_seq_pkg` holds:
  - state enum: IDLE, ERR, INTG, ICOMP, PCOMP, ACC1, ACC2.
  - src1 codes: ACCUM = 0, ITERM = 1, ERR_SE = 2, ERR_HALF = 3, FWD = 4.
  - src0 codes: A2D = 0, INTGRL = 1, ICOMP = 2, PCOMP = 3, PTERM = 4.
- The `alu` module imports the same package.
- No sub-module; the FSM and counters live in one module.

Test Plan:
1. Reset mid-run (in PCOMP) → all outputs 0, state IDLE, no `done`; the next `start` runs normally.
2. setpt = 0x100, a2d_res = 0x0C0, start; bench ALU = codebase `alu`, INT_DEC = 4 →
   - ERR control vector src1 = 0, src0 = 0, sub = 1, sat = 1.
   - `error` = 0x040.
   - INTG skipped.
   - `done` exactly 8 cycles after `start`; `drive` equals the reference-model value.
3. Four back-to-back starts (each issued in the `done` cycle) → INTG entered only on run 4 and `intgrl` = 0x040; runs 1–3 leave `intgrl` = 0.
4. `start` pulsed during ICOMP → ignored: `busy` stays high, a single `done`, `dec_cnt` unchanged.
5. MUL_CYCLES = 3, bench drives `dst` = 0x1234 on multiply cycles 0–1 and 0x5678 on cycle 2 → `icomp` = 0x5678; `multiply` high for exactly 3 cycles.
6. Bench forces `dst` = 0x07FF in ACC2 → `drive` = 0x7FF and `accum` = 0x07FF; `drive` holds until the next `done`.
